// File: rtl/mac_pkg.sv
// Shared types and width constants for the MACcore sequencer and its helpers.
package mac_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned WADDR_W = 5;
    localparam int unsigned ACC_W   = 17;
    localparam int unsigned GRID    = 16;
    localparam int unsigned SEL_W   = $clog2(GRID);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StIssue,
        StComp,
        StWait,
        StCapture
    } seq_state_e;

    typedef struct packed {
        logic [SEL_W-1:0]   row;
        logic [SEL_W-1:0]   col;
        logic [GRID-1:0]    row_en;
        logic [WADDR_W-1:0] last_tap;
    } job_cfg_t;

    function automatic logic [GRID-1:0] col_onehot(input logic [SEL_W-1:0] col);
        logic [GRID-1:0] oh;
        oh      = '0;
        oh[col] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Job, sample-stream and MACcore control signals between the scheduler side and the sequencer.
interface mac_sequencer_if;
    import mac_pkg::*;

    logic               start;
    logic [SEL_W-1:0]   cfgRow;
    logic [SEL_W-1:0]   cfgCol;
    logic [GRID-1:0]    cfgRowEn;
    logic [WADDR_W-1:0] cfgLastTap;
    logic [DATA_W-1:0]  dataIn;
    logic               dataValid;
    logic               dataReady;
    logic [DATA_W-1:0]  macData;
    logic [SEL_W-1:0]   macRow;
    logic [WADDR_W-1:0] macAddrWeight;
    logic [SEL_W-1:0]   macCol;
    logic [GRID-1:0]    macAddrEn;
    logic [SEL_W-1:0]   macAddrResult;
    logic               macNewData;
    logic               macComp;
    logic [GRID-1:0]    macColReset;
    logic [ACC_W-1:0]   macResult;
    logic [ACC_W-1:0]   resultOut;
    logic               resultValid;
    logic               busy;
    logic               done;

    modport slave (
        input  start, cfgRow, cfgCol, cfgRowEn, cfgLastTap, dataIn, dataValid, macResult,
        output dataReady, macData, macRow, macAddrWeight, macCol, macAddrEn, macAddrResult,
               macNewData, macComp, macColReset, resultOut, resultValid, busy, done
    );

    modport master (
        output start, cfgRow, cfgCol, cfgRowEn, cfgLastTap, dataIn, dataValid, macResult,
        input  dataReady, macData, macRow, macAddrWeight, macCol, macAddrEn, macAddrResult,
               macNewData, macComp, macColReset, resultOut, resultValid, busy, done
    );

endinterface

// File: rtl/mac_tap_counter.sv
// Loadable tap/weight-address counter with clear, enable and terminal compare.
module mac_tap_counter
    import mac_pkg::*;
#(
    parameter int unsigned Width = WADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] last_i,
    output logic [Width-1:0] cnt_o,
    output logic             term_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == last_i);
    assign cnt_o  = cnt_q;

    // Holds at the terminal value so a full-range job never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot-product job on the MACcore grid: clear column, stream taps, commit, capture.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned RES_LAT = 2
) (
    input  logic           Clk,
    input  logic           reset,
    mac_sequencer_if.slave bus_io
);

    localparam int unsigned WaitW = (RES_LAT > 2) ? $clog2(RES_LAT - 1) : 1;
    localparam logic [WaitW-1:0] WaitLast = (RES_LAT > 2) ? WaitW'(RES_LAT - 2) : '0;

    seq_state_e         state_q, state_d;
    job_cfg_t           cfg_q, cfg_d;
    logic [WaitW-1:0]   wait_q, wait_d;

    logic               data_ready_q, data_ready_d;
    logic [DATA_W-1:0]  mac_data_q, mac_data_d;
    logic [SEL_W-1:0]   mac_row_q, mac_row_d;
    logic [WADDR_W-1:0] mac_addr_weight_q, mac_addr_weight_d;
    logic [SEL_W-1:0]   mac_col_q, mac_col_d;
    logic [GRID-1:0]    mac_addr_en_q, mac_addr_en_d;
    logic [SEL_W-1:0]   mac_addr_result_q, mac_addr_result_d;
    logic               mac_new_data_q, mac_new_data_d;
    logic               mac_comp_q, mac_comp_d;
    logic [GRID-1:0]    mac_col_reset_q, mac_col_reset_d;
    logic [ACC_W-1:0]   result_out_q, result_out_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tap_clr, tap_en, tap_term, active;
    logic [WADDR_W-1:0] tap_cnt;

    assign tap_clr = (state_q == StClear);
    assign tap_en  = (state_q == StIssue);

    mac_tap_counter #(
        .Width (WADDR_W)
    ) u_tap_counter (
        .clk_i      (Clk),
        .rst_i      (reset),
        .clr_i      (tap_clr),
        .load_i     (1'b0),
        .load_val_i ({WADDR_W{1'b0}}),
        .en_i       (tap_en),
        .last_i     (cfg_q.last_tap),
        .cnt_o      (tap_cnt),
        .term_o     (tap_term)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        wait_d     = wait_q;
        mac_data_d = mac_data_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    cfg_d   = '{row:      bus_io.cfgRow,
                                col:      bus_io.cfgCol,
                                row_en:   bus_io.cfgRowEn,
                                last_tap: bus_io.cfgLastTap};
                    state_d = StClear;
                end
            end
            StClear: state_d = StFetch;
            StFetch: begin
                if (bus_io.dataValid && data_ready_q) begin
                    mac_data_d = bus_io.dataIn;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = tap_term ? StComp : StFetch;
            StComp: begin
                wait_d  = '0;
                state_d = (RES_LAT > 1) ? StWait : StCapture;
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StCapture;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so every one of them leaves a flop.
        active            = (state_d != StIdle);
        data_ready_d      = (state_d == StFetch);
        mac_row_d         = active ? cfg_d.row : '0;
        mac_col_d         = active ? cfg_d.col : '0;
        mac_addr_en_d     = active ? cfg_d.row_en : '0;
        mac_addr_result_d = active ? cfg_d.row : '0;
        mac_addr_weight_d = (state_d == StIssue) ? tap_cnt :
                            (active ? mac_addr_weight_q : '0);
        mac_new_data_d    = (state_d == StIssue);
        mac_comp_d        = (state_d == StComp);
        mac_col_reset_d   = (state_d == StClear) ? col_onehot(cfg_d.col) : '0;
        result_out_d      = (state_d == StCapture) ? bus_io.macResult : result_out_q;
        result_valid_d    = (state_d == StCapture);
        done_d            = (state_d == StCapture);
        busy_d            = active;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cfg_q             <= '0;
            wait_q            <= '0;
            data_ready_q      <= 1'b0;
            mac_data_q        <= '0;
            mac_row_q         <= '0;
            mac_addr_weight_q <= '0;
            mac_col_q         <= '0;
            mac_addr_en_q     <= '0;
            mac_addr_result_q <= '0;
            mac_new_data_q    <= 1'b0;
            mac_comp_q        <= 1'b0;
            mac_col_reset_q   <= '0;
            result_out_q      <= '0;
            result_valid_q    <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cfg_q             <= cfg_d;
            wait_q            <= wait_d;
            data_ready_q      <= data_ready_d;
            mac_data_q        <= mac_data_d;
            mac_row_q         <= mac_row_d;
            mac_addr_weight_q <= mac_addr_weight_d;
            mac_col_q         <= mac_col_d;
            mac_addr_en_q     <= mac_addr_en_d;
            mac_addr_result_q <= mac_addr_result_d;
            mac_new_data_q    <= mac_new_data_d;
            mac_comp_q        <= mac_comp_d;
            mac_col_reset_q   <= mac_col_reset_d;
            result_out_q      <= result_out_d;
            result_valid_q    <= result_valid_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign bus_io.dataReady     = data_ready_q;
    assign bus_io.macData       = mac_data_q;
    assign bus_io.macRow        = mac_row_q;
    assign bus_io.macAddrWeight = mac_addr_weight_q;
    assign bus_io.macCol        = mac_col_q;
    assign bus_io.macAddrEn     = mac_addr_en_q;
    assign bus_io.macAddrResult = mac_addr_result_q;
    assign bus_io.macNewData    = mac_new_data_q;
    assign bus_io.macComp       = mac_comp_q;
    assign bus_io.macColReset   = mac_col_reset_q;
    assign bus_io.resultOut     = result_out_q;
    assign bus_io.resultValid   = result_valid_q;
    assign bus_io.busy          = busy_q;
    assign bus_io.done          = done_q;

endmodule
